// File: rtl/spi_block_xfer.sv
// Byte sequencer for SPI_Master_With_Single_CS: sends a command byte plus 0..16 data bytes
// and gathers MISO bytes into a right-aligned 128-bit response. SPI_XFER_TIMEOUT_EN adds an RX timeout.
module spi_block_xfer #(
  parameter int         MAX_DATA_BYTES = 16,
  parameter logic [7:0] FILL_BYTE      = 8'h00,
  parameter int         TIMEOUT_CYCLES = 4096
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [7:0]   cmd_byte,
  input  logic [4:0]   cmd_nbytes,
  input  logic         cmd_has_pl,
  input  logic [127:0] cmd_payload,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic [4:0]   spi_tx_count,
  output logic [7:0]   spi_tx_byte,
  output logic         spi_tx_dv,
  input  logic         spi_tx_ready,
  input  logic         spi_rx_dv,
  input  logic [7:0]   spi_rx_byte
);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_RX, DONE} state_t;

  state_t         state, state_nx;
  logic [7:0]     cmd_q;
  logic [4:0]     n_q, idx;
  logic           pl_q;
  logic [127:0]   pl_sh;
  logic [4:0]     n_clamp;
  logic           accept, tmo;

  assign n_clamp   = (cmd_nbytes > 5'(MAX_DATA_BYTES)) ? 5'(MAX_DATA_BYTES) : cmd_nbytes;
  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign accept    = cmd_valid && cmd_ready;

`ifdef SPI_XFER_TIMEOUT_EN
  logic [12:0] tmo_cnt;

  // Counts idle cycles of the current byte; any RX byte restarts the window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                             tmo_cnt <= '0;
    else if (state != WAIT_RX || spi_rx_dv) tmo_cnt <= '0;
    else                                   tmo_cnt <= tmo_cnt + 13'd1;
  end

  assign tmo = (state == WAIT_RX) && !spi_rx_dv && (tmo_cnt == 13'(TIMEOUT_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = LOAD;
      LOAD:    state_nx = SEND;
      SEND:    if (spi_tx_ready) state_nx = WAIT_RX;
      WAIT_RX: begin
        if (spi_rx_dv) state_nx = (idx == n_q) ? DONE : SEND;
        else if (tmo)  state_nx = DONE;
      end
      DONE:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q        <= '0;
      n_q          <= '0;
      idx          <= '0;
      pl_q         <= 1'b0;
      pl_sh        <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
      spi_tx_count <= '0;
      spi_tx_byte  <= '0;
      spi_tx_dv    <= 1'b0;
    end else begin
      spi_tx_dv <= 1'b0;
      if (accept) begin
        cmd_q        <= cmd_byte;
        n_q          <= n_clamp;
        pl_q         <= cmd_has_pl;
        pl_sh        <= cmd_payload;
        idx          <= '0;
        rsp_data     <= '0;
        rsp_err      <= 1'b0;
        spi_tx_count <= n_clamp + 5'd1;
      end
      if (state == SEND && spi_tx_ready) begin
        spi_tx_dv <= 1'b1;
        if (idx == 5'd0) begin
          spi_tx_byte <= cmd_q;
        end else begin
          // Payload is consumed MSB-first by shifting one byte out per data slot.
          spi_tx_byte <= pl_q ? pl_sh[127:120] : FILL_BYTE;
          pl_sh       <= {pl_sh[119:0], 8'h00};
        end
      end
      if (state == WAIT_RX && spi_rx_dv) begin
        if (idx != 5'd0) rsp_data <= {rsp_data[119:0], spi_rx_byte};
        if (idx != n_q)  idx <= idx + 5'd1;
      end
      if (tmo) rsp_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_block_xfer.sv
// Scoreboard bench for spi_block_xfer: a byte-level SPI master model answers each tx byte,
// monitors check MOSI bytes and responses against queued expectations.
module tb_spi_block_xfer;
  localparam int TMO = 64;
  localparam int BT  = 20;

  logic         clk = 1'b0, reset = 1'b1;
  logic         cmd_valid = 1'b0, cmd_ready, cmd_has_pl = 1'b0;
  logic [7:0]   cmd_byte = '0;
  logic [4:0]   cmd_nbytes = '0;
  logic [127:0] cmd_payload = '0;
  logic         rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [127:0] rsp_data;
  logic [4:0]   spi_tx_count;
  logic [7:0]   spi_tx_byte;
  logic         spi_tx_dv, spi_tx_ready = 1'b1, spi_rx_dv = 1'b0;
  logic [7:0]   spi_rx_byte = '0;

  typedef struct {logic [127:0] data; logic err; logic [4:0] cnt;} rsp_t;

  logic [7:0] exp_tx[$];
  rsp_t       exp_rsp[$];
  logic [7:0] miso_q[$];
  rsp_t       e;
  int total = 0, bad = 0, dv_count = 0, since_rx = 0;

  always #5 clk = ~clk;

  spi_block_xfer #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_byte(cmd_byte), .cmd_nbytes(cmd_nbytes), .cmd_has_pl(cmd_has_pl),
    .cmd_payload(cmd_payload), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .spi_tx_count(spi_tx_count),
    .spi_tx_byte(spi_tx_byte), .spi_tx_dv(spi_tx_dv), .spi_tx_ready(spi_tx_ready),
    .spi_rx_dv(spi_rx_dv), .spi_rx_byte(spi_rx_byte)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  // SPI master model: busy for BT cycles per byte, answers only while MISO data is queued.
  always begin
    @(negedge clk);
    if (!reset && spi_tx_dv) begin
      spi_tx_ready = 1'b0;
      repeat (BT) @(negedge clk);
      if (!reset && miso_q.size() > 0) begin
        spi_rx_byte = miso_q.pop_front();
        spi_rx_dv   = 1'b1;
        @(negedge clk);
        spi_rx_dv   = 1'b0;
      end
      spi_tx_ready = 1'b1;
    end
  end

  // Monitor: MOSI bytes and consumed responses against the scoreboard queues.
  always @(negedge clk) begin
    since_rx = spi_rx_dv ? 0 : since_rx + 1;
    if (!reset) begin
      if (spi_tx_dv) begin
        dv_count++;
        if (exp_tx.size() == 0) fail_now("unexpected_tx");
        else chk("mosi", spi_tx_byte, exp_tx.pop_front());
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_rsp.size() == 0) fail_now("unexpected_rsp");
        else begin
          e = exp_rsp.pop_front();
          chk("rsp_data", rsp_data, e.data);
          chk("rsp_err", rsp_err, e.err);
          chk("tx_count", spi_tx_count, e.cnt);
        end
      end
    end
  end

  task automatic send(input logic [7:0] c, input logic [4:0] nb, input logic pl,
                      input logic [127:0] p);
    int n;
    bit ok;
    n = (nb > 16) ? 16 : int'(nb);
    exp_tx.push_back(c);
    for (int k = 1; k <= n; k++) exp_tx.push_back(pl ? p[127-8*(k-1) -: 8] : 8'h00);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_byte = c; cmd_nbytes = nb; cmd_has_pl = pl; cmd_payload = p;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      else @(negedge clk);
    end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    if (!ok) fail_now("accept_timeout");
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 3000 && exp_rsp.size() != 0; i++) @(negedge clk);
    if (exp_rsp.size() != 0) fail_now("rsp_timeout");
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_rsp_valid();
    int i;
    for (i = 0; i < 3000 && !rsp_valid; i++) @(negedge clk);
    if (!rsp_valid) fail_now("rsp_valid_timeout");
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready, 1'b1);
    chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
    chk({tag, "_tx_count"}, spi_tx_count, 5'd0);
    chk({tag, "_tx_dv"}, spi_tx_dv, 1'b0);
    chk({tag, "_rsp_data"}, rsp_data, 128'h0);
    chk({tag, "_tx_byte"}, spi_tx_byte, 8'h00);
  endtask

  initial begin
    rsp_t r;
    logic [127:0] snap;
    bit stable;
    int gap;

    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    chk("rst_rsp_err", rsp_err, 1'b0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // Fill-byte frame, MISO counts up 0x00..0x10
    for (int i = 0; i <= 16; i++) miso_q.push_back(8'(i));
    r = '{128'h0102030405060708090a0b0c0d0e0f10, 1'b0, 5'd17}; exp_rsp.push_back(r);
    send(8'h10, 5'd16, 1'b0, 128'h0);
    wait_idle();

    // Payload frame
    for (int i = 0; i <= 16; i++) miso_q.push_back(8'h80 + 8'(i));
    r = '{128'h8182838485868788898a8b8c8d8e8f90, 1'b0, 5'd17}; exp_rsp.push_back(r);
    send(8'h11, 5'd16, 1'b1, 128'h39558d1f193656ab8b4b65e25ac48474);
    wait_idle();

    // Command-only frame
    miso_q.push_back(8'h55);
    r = '{128'h0, 1'b0, 5'd1}; exp_rsp.push_back(r);
    send(8'h12, 5'd0, 1'b0, 128'h0);
    wait_idle();

    // Clamped length with a stalled consumer and a competing request
    rsp_ready = 1'b0;
    dv_count  = 0;
    for (int i = 0; i <= 16; i++) miso_q.push_back(8'h20 + 8'(i));
    r = '{128'h2122232425262728292a2b2c2d2e2f30, 1'b0, 5'd17}; exp_rsp.push_back(r);
    send(8'h13, 5'd20, 1'b1, 128'h00112233445566778899aabbccddeeff);
    wait_rsp_valid();
    snap = rsp_data;
    stable = 1'b1;
    cmd_valid = 1'b1; cmd_byte = 8'h44; cmd_nbytes = 5'd2;
    repeat (50) begin
      @(negedge clk);
      if (rsp_data !== snap || !rsp_valid || cmd_ready) stable = 1'b0;
    end
    chk("hold_stable", stable, 1'b1);
    chk("dv_pulses", dv_count, 17);
    cmd_valid = 1'b0;
    @(negedge clk);
    rsp_ready = 1'b1;
    wait_idle();

    // Reset in the middle of a frame
    dv_count = 0;
    for (int i = 0; i <= 16; i++) miso_q.push_back(8'(i));
    send(8'h10, 5'd16, 1'b1, 128'h39558d1f193656ab8b4b65e25ac48474);
    for (int i = 0; i < 3000 && dv_count < 6; i++) @(negedge clk);
    if (dv_count < 6) fail_now("byte5_timeout");
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    exp_tx.delete();
    miso_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (60) @(negedge clk);
    miso_q.push_back(8'h00); miso_q.push_back(8'h01);
    miso_q.push_back(8'h02); miso_q.push_back(8'h03);
    r = '{128'h010203, 1'b0, 5'd4}; exp_rsp.push_back(r);
    send(8'h12, 5'd3, 1'b1, 128'hdeadbeef000000000000000000000000);
    wait_idle();

`ifdef SPI_XFER_TIMEOUT_EN
    // MISO dries up after data byte 3
    miso_q.push_back(8'h00); miso_q.push_back(8'h0a);
    miso_q.push_back(8'h0b); miso_q.push_back(8'h0c);
    rsp_ready = 1'b0;
    r = '{128'h0a0b0c, 1'b1, 5'd17}; exp_rsp.push_back(r);
    send(8'h10, 5'd16, 1'b0, 128'h0);
    wait_rsp_valid();
    gap = since_rx;
    chk("tmo_gap_ok", (gap >= TMO - 4 && gap <= TMO + 6), 1'b1);
    rsp_ready = 1'b1;
    wait_idle();
    exp_tx.delete();
`endif

    chk("tx_queue_empty", exp_tx.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
